// File: rtl/riscv_defines.sv
// Shared definitions for the instruction-alignment front end: aligner states and
// a small helper for classifying 16-bit instruction parcels.
package riscv_defines;

    typedef enum logic [1:0] {
        ALIGNED = 2'd0,
        HALF    = 2'd1,
        BR_MIS  = 2'd2
    } align_state_e;

    localparam logic [1:0] OPC_FULL_WIDTH = 2'b11;

    // A parcel starts a compressed instruction unless its two LSBs are both set.
    function automatic logic parcel_is_compressed(input logic [15:0] parcel);
        return parcel[1:0] != OPC_FULL_WIDTH;
    endfunction

endpackage

// File: rtl/riscv_instr_aligner.sv
// Realigns a stream of word-aligned 32-bit fetch words into whole RV32IC instructions,
// carrying a 16-bit residual parcel across word boundaries.
module riscv_instr_aligner
    import riscv_defines::*;
#(
    parameter logic [31:0] BOOT_ADDR = 32'h0000_0080
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        fetch_valid_i,
    input  logic [31:0] fetch_rdata_i,
    output logic        fetch_ready_o,
    output logic        instr_valid_o,
    output logic [31:0] instr_o,
    output logic [31:0] instr_addr_o,
    output logic        instr_is_compressed_o,
    input  logic        id_ready_i,
    input  logic        branch_i,
    input  logic [31:0] branch_addr_i
);

    align_state_e state_reg, state_next;
    logic [31:0]  pc_reg, pc_next;
    logic [15:0]  res_reg, res_next;

    logic [31:0]  instr_next;
    logic         instr_valid_next;
    logic         fetch_ready_next;

    logic [15:0]  rdata_lo;
    logic [15:0]  rdata_hi;

    // Bit 0 of both addresses is architecturally always zero and is dropped.
    logic unused_addr_bits;
    assign unused_addr_bits = branch_addr_i[0] ^ BOOT_ADDR[0];

    assign rdata_lo = fetch_rdata_i[15:0];
    assign rdata_hi = fetch_rdata_i[31:16];

    always_comb begin
        state_next       = state_reg;
        pc_next          = pc_reg;
        res_next         = res_reg;
        instr_next       = fetch_rdata_i;
        instr_valid_next = 1'b0;
        fetch_ready_next = 1'b0;

        unique case (state_reg)
            ALIGNED: begin
                instr_valid_next = fetch_valid_i;
                if (parcel_is_compressed(rdata_lo)) begin
                    instr_next = {16'h0000, rdata_lo};
                    if (fetch_valid_i && id_ready_i) begin
                        fetch_ready_next = 1'b1;
                        res_next         = rdata_hi;
                        pc_next          = pc_reg + 32'd2;
                        state_next       = HALF;
                    end
                end else begin
                    instr_next = fetch_rdata_i;
                    if (fetch_valid_i && id_ready_i) begin
                        fetch_ready_next = 1'b1;
                        pc_next          = pc_reg + 32'd4;
                    end
                end
            end

            HALF: begin
                if (parcel_is_compressed(res_reg)) begin
                    // Residual is a whole instruction; the pending fetch word is left untouched.
                    instr_next       = {16'h0000, res_reg};
                    instr_valid_next = 1'b1;
                    if (id_ready_i) begin
                        pc_next    = pc_reg + 32'd2;
                        state_next = ALIGNED;
                    end
                end else begin
                    instr_next       = {rdata_lo, res_reg};
                    instr_valid_next = fetch_valid_i;
                    if (fetch_valid_i && id_ready_i) begin
                        fetch_ready_next = 1'b1;
                        res_next         = rdata_hi;
                        pc_next          = pc_reg + 32'd4;
                    end
                end
            end

            BR_MIS: begin
                instr_next = {16'h0000, rdata_hi};
                if (parcel_is_compressed(rdata_hi)) begin
                    instr_valid_next = fetch_valid_i;
                    if (fetch_valid_i && id_ready_i) begin
                        fetch_ready_next = 1'b1;
                        pc_next          = pc_reg + 32'd2;
                        state_next       = ALIGNED;
                    end
                end else if (fetch_valid_i) begin
                    // First half of a 32-bit target: absorb it without needing decode.
                    fetch_ready_next = 1'b1;
                    res_next         = rdata_hi;
                    state_next       = HALF;
                end
            end

            default: begin
                state_next = ALIGNED;
            end
        endcase

        if (branch_i) begin
            instr_valid_next = 1'b0;
            fetch_ready_next = 1'b1;
            pc_next          = {branch_addr_i[31:1], 1'b0};
            res_next         = 16'h0000;
            state_next       = branch_addr_i[1] ? BR_MIS : ALIGNED;
        end

        if (rst) begin
            instr_valid_next = 1'b0;
            fetch_ready_next = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= ALIGNED;
            pc_reg    <= {BOOT_ADDR[31:1], 1'b0};
            res_reg   <= 16'h0000;
        end else begin
            state_reg <= state_next;
            pc_reg    <= pc_next;
            res_reg   <= res_next;
        end
    end

    assign instr_o               = instr_next;
    assign instr_valid_o         = instr_valid_next;
    assign fetch_ready_o         = fetch_ready_next;
    assign instr_addr_o          = pc_reg;
    assign instr_is_compressed_o = instr_next[1:0] != OPC_FULL_WIDTH;

endmodule

// File: tb/tb_riscv_instr_aligner.sv
// Directed bench for the instruction aligner: expected instructions are queued as each
// fetch word is presented and retired when the aligner hands an instruction to decode.
module tb_riscv_instr_aligner;

    logic        clk;
    logic        rst;
    logic        fetch_valid_i;
    logic [31:0] fetch_rdata_i;
    logic        fetch_ready_o;
    logic        instr_valid_o;
    logic [31:0] instr_o;
    logic [31:0] instr_addr_o;
    logic        instr_is_compressed_o;
    logic        id_ready_i;
    logic        branch_i;
    logic [31:0] branch_addr_i;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] addr;
        logic        comp;
    } exp_t;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;

    riscv_instr_aligner #(.BOOT_ADDR(32'h0000_0080)) dut (
        .clk                   (clk),
        .rst                   (rst),
        .fetch_valid_i         (fetch_valid_i),
        .fetch_rdata_i         (fetch_rdata_i),
        .fetch_ready_o         (fetch_ready_o),
        .instr_valid_o         (instr_valid_o),
        .instr_o               (instr_o),
        .instr_addr_o          (instr_addr_o),
        .instr_is_compressed_o (instr_is_compressed_o),
        .id_ready_i            (id_ready_i),
        .branch_i              (branch_i),
        .branch_addr_i         (branch_addr_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Inputs change on the falling edge; outputs are sampled 1ns later.
    task automatic drive(input logic r, input logic fv, input logic [31:0] fd,
                         input logic idr, input logic br, input logic [31:0] ba);
        rst           = r;
        fetch_valid_i = fv;
        fetch_rdata_i = fd;
        id_ready_i    = idr;
        branch_i      = br;
        branch_addr_i = ba;
        #1;
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic retire();
        exp_t e;
        if (instr_valid_o && id_ready_i) begin
            if (sb.size() == 0) begin
                chk("sb_unexpected_xfer", 32'd1, 32'd0);
            end else begin
                e = sb.pop_front();
                $display("xfer addr=%h instr=%h compressed=%0b", instr_addr_o, instr_o,
                         instr_is_compressed_o);
                chk("xfer_instr", instr_o, e.instr);
                chk("xfer_addr", instr_addr_o, e.addr);
                chk("xfer_comp", {31'd0, instr_is_compressed_o}, {31'd0, e.comp});
            end
        end
    endtask

    task automatic expect_xfer(input logic [31:0] instr, input logic [31:0] addr,
                               input logic comp);
        exp_t e;
        e.instr = instr;
        e.addr  = addr;
        e.comp  = comp;
        sb.push_back(e);
        chk("xfer_valid", {31'd0, instr_valid_o}, 32'd1);
        retire();
    endtask

    logic [31:0] held_instr;

    initial begin
        // Reset cycle with branch and fetch activity present: reset wins.
        drive(1, 1, 32'h00A0_0093, 1, 1, 32'h0000_0400);
        chk("rst_valid", {31'd0, instr_valid_o}, 32'd0);
        chk("rst_fready", {31'd0, fetch_ready_o}, 32'd0);
        step();
        drive(0, 0, 32'h0, 1, 0, 32'h0);
        chk("boot_addr", instr_addr_o, 32'h0000_0080);
        chk("boot_nodata_valid", {31'd0, instr_valid_o}, 32'd0);
        chk("boot_nodata_fready", {31'd0, fetch_ready_o}, 32'd0);

        // 32-bit instruction, zero latency.
        drive(0, 1, 32'h00A0_0093, 1, 0, 32'h0);
        chk("w32_fready", {31'd0, fetch_ready_o}, 32'd1);
        expect_xfer(32'h00A0_0093, 32'h0000_0080, 1'b0);
        step();
        drive(0, 0, 32'h0, 1, 0, 32'h0);
        chk("w32_next_addr", instr_addr_o, 32'h0000_0084);

        // Branch with no fetch data still drops the pending word.
        drive(0, 0, 32'h0, 1, 1, 32'h0000_0100);
        chk("br_valid", {31'd0, instr_valid_o}, 32'd0);
        chk("br_fready", {31'd0, fetch_ready_o}, 32'd1);
        step();

        // Two compressed instructions in one word.
        drive(0, 1, 32'h4501_4585, 1, 0, 32'h0);
        chk("cc_fready1", {31'd0, fetch_ready_o}, 32'd1);
        expect_xfer(32'h0000_4585, 32'h0000_0100, 1'b1);
        step();
        drive(0, 0, 32'h0, 1, 0, 32'h0);
        chk("cc_fready2", {31'd0, fetch_ready_o}, 32'd0);
        expect_xfer(32'h0000_4501, 32'h0000_0102, 1'b1);
        step();

        // Straddling 32-bit instruction.
        drive(0, 0, 32'h0, 1, 1, 32'h0000_0100);
        step();
        drive(0, 1, 32'h0093_4585, 1, 0, 32'h0);
        expect_xfer(32'h0000_4585, 32'h0000_0100, 1'b1);
        step();
        drive(0, 1, 32'hFFFF_00A0, 1, 0, 32'h0);
        chk("strad_fready", {31'd0, fetch_ready_o}, 32'd1);
        expect_xfer(32'h00A0_0093, 32'h0000_0102, 1'b0);
        step();
        drive(0, 0, 32'h0, 1, 0, 32'h0);
        chk("half32_nodata_valid", {31'd0, instr_valid_o}, 32'd0);
        chk("half32_nodata_fready", {31'd0, fetch_ready_o}, 32'd0);

        // Decode stall in HALF with a 32-bit residual: nothing moves.
        drive(0, 1, 32'h1234_5678, 0, 0, 32'h0);
        held_instr = instr_o;
        chk("stall_instr0", held_instr, 32'h5678_FFFF);
        for (int i = 0; i < 3; i++) begin
            step();
            drive(0, 1, 32'h1234_5678, 0, 0, 32'h0);
            chk("stall_instr", instr_o, 32'h5678_FFFF);
            chk("stall_addr", instr_addr_o, 32'h0000_0106);
            chk("stall_fready", {31'd0, fetch_ready_o}, 32'd0);
        end
        drive(0, 1, 32'h1234_5678, 1, 0, 32'h0);
        expect_xfer(32'h5678_FFFF, 32'h0000_0106, 1'b0);
        step();

        // Compressed residual is emitted without fetch data; branch mid-stall flushes it.
        drive(0, 0, 32'h0, 0, 0, 32'h0);
        chk("halfc_valid", {31'd0, instr_valid_o}, 32'd1);
        chk("halfc_instr", instr_o, 32'h0000_1234);
        chk("halfc_fready", {31'd0, fetch_ready_o}, 32'd0);
        step();
        drive(0, 0, 32'h0, 0, 1, 32'h0000_0206);
        chk("brstall_valid", {31'd0, instr_valid_o}, 32'd0);
        chk("brstall_fready", {31'd0, fetch_ready_o}, 32'd1);
        step();

        // Misaligned branch target, compressed upper half.
        drive(0, 1, 32'h4505_0000, 1, 0, 32'h0);
        chk("brmis_fready", {31'd0, fetch_ready_o}, 32'd1);
        expect_xfer(32'h0000_4505, 32'h0000_0206, 1'b1);
        step();
        drive(0, 0, 32'h0, 1, 0, 32'h0);
        chk("brmis_next_addr", instr_addr_o, 32'h0000_0208);
        chk("brmis_next_valid", {31'd0, instr_valid_o}, 32'd0);

        // Misaligned branch target, 32-bit upper half: absorbed even while decode stalls.
        drive(0, 0, 32'h0, 1, 1, 32'h0000_0302);
        step();
        drive(0, 1, 32'h0513_0000, 0, 0, 32'h0);
        chk("brmis32_valid", {31'd0, instr_valid_o}, 32'd0);
        chk("brmis32_fready", {31'd0, fetch_ready_o}, 32'd1);
        step();
        drive(0, 1, 32'hABCD_00A5, 1, 0, 32'h0);
        expect_xfer(32'h00A5_0513, 32'h0000_0302, 1'b0);
        step();

        // Reset during a stall with a compressed residual pending, branch also raised.
        drive(0, 0, 32'h0, 0, 0, 32'h0);
        chk("pre_rst_instr", instr_o, 32'h0000_ABCD);
        chk("pre_rst_addr", instr_addr_o, 32'h0000_0306);
        drive(1, 1, 32'h0000_0001, 0, 1, 32'h0000_0500);
        chk("midrst_valid", {31'd0, instr_valid_o}, 32'd0);
        chk("midrst_fready", {31'd0, fetch_ready_o}, 32'd0);
        step();
        drive(0, 0, 32'h0, 1, 0, 32'h0);
        chk("postrst_addr", instr_addr_o, 32'h0000_0080);
        chk("postrst_valid", {31'd0, instr_valid_o}, 32'd0);

        // PC wraps modulo 2^32.
        drive(0, 0, 32'h0, 1, 1, 32'hFFFF_FFFE);
        step();
        drive(0, 1, 32'h0001_7777, 1, 0, 32'h0);
        expect_xfer(32'h0000_0001, 32'hFFFF_FFFE, 1'b1);
        step();
        drive(0, 0, 32'h0, 1, 0, 32'h0);
        chk("wrap_addr", instr_addr_o, 32'h0000_0000);

        // Branch target bit 0 is ignored.
        drive(0, 0, 32'h0, 1, 1, 32'h0000_0201);
        step();
        drive(0, 1, 32'h0000_0013, 1, 0, 32'h0);
        expect_xfer(32'h0000_0013, 32'h0000_0200, 1'b0);
        step();

        drive(0, 0, 32'h0, 1, 0, 32'h0);
        chk("sb_drained", sb.size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "bench time limit");
    end

endmodule
